// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX stage register, N operand lanes + instr + ctrl, flush-to-bubble, optional skid (PIPE_REG_SKID_EN).
// Latency: 1 cycle from input transfer to out_valid; one beat per cycle while out_ready=1.
// Backpressure: skid build gives a registered in_ready (!skid_full); plain build gives in_ready = !out_valid || out_ready.
module id_ex_pipe_reg #(
  parameter int DATA_W   = 8,
  parameter int NUM_OPND = 2,
  parameter int INSTR_W  = 19,
  parameter int CTRL_W   = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_OPND*DATA_W-1:0] in_opnd,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_OPND*DATA_W-1:0] out_opnd,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [15:0]                stall_cnt
);

  localparam int OPND_W = NUM_OPND * DATA_W;

  // M can take a new beat when it is empty or its beat leaves on this edge
  logic m_free;
  logic in_xfer;
  logic m_load;
  logic [OPND_W-1:0]  m_src_opnd;
  logic [INSTR_W-1:0] m_src_instr;
  logic [CTRL_W-1:0]  m_src_ctrl;

  assign m_free  = !out_valid || out_ready;
  assign in_xfer = in_valid && in_ready;

`ifdef PIPE_REG_SKID_EN
  logic               s_valid;
  logic [OPND_W-1:0]  s_opnd;
  logic [INSTR_W-1:0] s_instr;
  logic [CTRL_W-1:0]  s_ctrl;

  // Ready comes straight from the skid flop; flush forces it so offered beats are swallowed
  assign in_ready = !s_valid || flush;

  // The skid beat is older than anything on the input, so it refills M first
  assign m_load      = s_valid || in_xfer;
  assign m_src_opnd  = s_valid ? s_opnd  : in_opnd;
  assign m_src_instr = s_valid ? s_instr : in_instr;
  assign m_src_ctrl  = s_valid ? s_ctrl  : in_ctrl;

  // Skid entry: captures a beat accepted while M is stalled, empties when M frees up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_opnd  <= '0;
      s_instr <= '0;
      s_ctrl  <= '0;
    end else if (flush) begin
      s_valid <= 1'b0;
    end else if (m_free) begin
      s_valid <= 1'b0;
    end else if (in_xfer) begin
      s_valid <= 1'b1;
      s_opnd  <= in_opnd;
      s_instr <= in_instr;
      s_ctrl  <= in_ctrl;
    end
  end
`else
  // Without a skid entry the stage only accepts when M will be free on this edge
  assign in_ready = m_free || flush;

  assign m_load      = in_xfer;
  assign m_src_opnd  = in_opnd;
  assign m_src_instr = in_instr;
  assign m_src_ctrl  = in_ctrl;
`endif

  // Main register: load, hold, or drain to a bubble with control cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_opnd  <= '0;
      out_instr <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (m_free) begin
      if (m_load) begin
        out_valid <= 1'b1;
        out_opnd  <= m_src_opnd;
        out_instr <= m_src_instr;
        out_ctrl  <= m_src_ctrl;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end
  end

  // Saturating stall counter; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed bench for id_ex_pipe_reg (default parameters, either build of PIPE_REG_SKID_EN).
// Latency: checks 1-cycle input-to-output timing and drain/flush bubbles.
// Backpressure: checks acceptance counts, stall counting and saturation under out_ready=0.
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_opnd;
  logic [18:0] in_instr;
  logic [12:0] in_ctrl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_opnd;
  logic [18:0] out_instr;
  logic [12:0] out_ctrl;
  logic [15:0] stall_cnt;

  int errors;
  int checks;

`ifdef PIPE_REG_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  id_ex_pipe_reg dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opnd   (in_opnd),
    .in_instr  (in_instr),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opnd  (out_opnd),
    .out_instr (out_instr),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset across one edge and leave all inputs idle
  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_opnd   = '0;
    in_instr  = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_opnd   = '0;
    in_instr  = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_opnd !== 16'h0) begin errors++; $display("FAIL rst_out_opnd: got %h want 0000", out_opnd); end
    checks++; if (out_instr !== 19'h0) begin errors++; $display("FAIL rst_out_instr: got %h want 00000", out_instr); end
    checks++; if (out_ctrl !== 13'h0) begin errors++; $display("FAIL rst_out_ctrl: got %h want 0000", out_ctrl); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_stall_cnt: got %h want 0000", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_held: got %b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [15:0] bo [4];
    logic [18:0] bi [4];
    logic [12:0] bc [4];
    bo[0] = 16'hA155; bi[0] = 19'h7_1234; bc[0] = 13'h1FFF;
    bo[1] = 16'h5AA1; bi[1] = 19'h0_ABCD; bc[1] = 13'h0001;
    bo[2] = 16'h3C96; bi[2] = 19'h5_5555; bc[2] = 13'h1000;
    bo[3] = 16'hF00F; bi[3] = 19'h2_AAAA; bc[3] = 13'h0AAA;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_opnd  = bo[i];
      in_instr = bi[i];
      in_ctrl  = bc[i];
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_opnd !== bo[i]) begin errors++; $display("FAIL stream_opnd[%0d]: got %h want %h", i, out_opnd, bo[i]); end
      checks++; if (out_instr !== bi[i]) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, bi[i]); end
      checks++; if (out_ctrl !== bc[i]) begin errors++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, bc[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b want 0", out_valid); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL stream_stall_cnt: got %h want 0000", stall_cnt); end
  endtask

  task automatic test_back_pressure();
    int acc;
    logic [15:0] exp_opnd [$];
    logic [15:0] e;
    do_reset();
    acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    // Six edges: first loads M, the next five are stalled
    for (int i = 0; i < 6; i++) begin
      in_opnd  = 16'hB000 + 16'(acc);
      in_instr = 19'h1_0000 + 19'(acc);
      in_ctrl  = 13'h0100 + 13'(acc);
      if (in_ready === 1'b1) begin
        exp_opnd.push_back(in_opnd);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (acc != EXP_ACC) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", acc, EXP_ACC); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
    out_ready = 1'b1;
    while (exp_opnd.size() > 0) begin
      e = exp_opnd.pop_front();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid: got %b want 1", out_valid); end
      checks++; if (out_opnd !== e) begin errors++; $display("FAIL bp_drain_order: got %h want %h", out_opnd, e); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_empty: got %b want 0", out_valid); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL bp_stall_hold: got %0d want 5", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_opnd   = 16'hC001; in_instr = 19'h3_0001; in_ctrl = 13'h1111;
    @(posedge clk); #1;
    in_opnd   = 16'hC002; in_instr = 19'h3_0002; in_ctrl = 13'h0222;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    flush    = 1'b1;
    in_opnd  = 16'hC003; in_instr = 19'h3_0003; in_ctrl = 13'h0333;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_during: got %b want 1", in_ready); end
    @(posedge clk); #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== 13'h0) begin errors++; $display("FAIL flush_ctrl: got %h want 0000", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_after: got %b want 1", in_ready); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_stall_cnt: got %0d want 2", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got valid %b opnd %h want valid 0", i, out_valid, out_opnd); end
    end
  endtask

  task automatic test_drain_bubble();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_opnd   = 16'h1234; in_instr = 19'h4_2A5C; in_ctrl = 13'h0C01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_ctrl !== 13'h0C01) begin errors++; $display("FAIL drain_load_ctrl: got %h want 0c01", out_ctrl); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== 13'h0) begin errors++; $display("FAIL drain_ctrl: got %h want 0000", out_ctrl); end
    checks++; if (out_instr !== 19'h4_2A5C) begin errors++; $display("FAIL drain_instr_hold: got %h want 42a5c", out_instr); end
    checks++; if (out_opnd !== 16'h1234) begin errors++; $display("FAIL drain_opnd_hold: got %h want 1234", out_opnd); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_opnd   = 16'h5A5A; in_instr = 19'h0_0F0F; in_ctrl = 13'h0055;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", stall_cnt); end
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
    repeat (4465) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_opnd   = 16'hD00D; in_instr = 19'h6_6666; in_ctrl = 13'h1ABC;
    @(posedge clk); #1;
    in_opnd   = 16'hD00E; in_instr = 19'h6_6667; in_ctrl = 13'h0ABD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== 13'h0) begin errors++; $display("FAIL areset_ctrl: got %h want 0000", out_ctrl); end
    checks++; if (out_opnd !== 16'h0) begin errors++; $display("FAIL areset_opnd: got %h want 0000", out_opnd); end
    checks++; if (out_instr !== 19'h0) begin errors++; $display("FAIL areset_instr: got %h want 00000", out_instr); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL areset_stall: got %h want 0000", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_lost_beat: got %b want 0", out_valid); end
  endtask

  // Run every scenario in order, then report
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_drain_bubble();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline stage register with a valid/ready handshake, flush-to-bubble, and an optional skid entry. It replaces the fixed-width, always-advancing ID/EX register between decode and execute. It carries N operand lanes, the instruction word and a packed control vector bit-exact. It lets execute back-pressure decode and lets hazard logic squash the stage.

## Interface
- DATA_W, 8, width of one operand lane
- NUM_OPND, 2, number of operand lanes (A, B, ...); lane k occupies bits [k*DATA_W +: DATA_W]
- INSTR_W, 19, instruction word width
- CTRL_W, 13, packed control vector width; bit order preserved exactly, no field remapping
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  decode offers a beat
- in_ready  out  1  stage accepts a beat this cycle
- in_opnd  in  NUM_OPND*DATA_W  register-file read data
- in_instr  in  INSTR_W  decoded instruction
- in_ctrl  in  CTRL_W  controller outputs
- flush  in  1  squash all held and incoming beats
- out_valid  out  1  execute-side beat valid
- out_ready  in  1  execute consumes the beat
- out_opnd  out  NUM_OPND*DATA_W  registered operands
- out_instr  out  INSTR_W  registered instruction
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Main register (M) drives the out_* ports.
- If M is empty, or its beat transfers out this cycle, an accepted input loads M. Otherwise the input goes to the skid entry (S, macro builds only).
- When M drains with nothing to replace it: out_valid=0 and out_ctrl is cleared to 0 (bubble). out_opnd and out_instr hold their last values.
- Flush has the highest priority, above every other event in the same cycle:
  - next cycle: out_valid=0, out_ctrl=0, S empty;
  - in_ready=1 during flush and any beat offered is consumed and discarded;
  - stall_cnt is unaffected.
- stall_cnt increments on each cycle with out_valid && !out_ready, saturates at 16'hFFFF, and is cleared only by reset.
- Reset values:
  - out_valid=0, out_opnd=0, out_instr=0, out_ctrl=0, stall_cnt=0;
  - S empty;
  - in_ready=1 (after reset deasserts, and also while reset is held).

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: one beat per cycle while out_ready=1.
- Reset asynchronously clears all state mid-transfer. A beat in flight when reset asserts is lost.
- Payload ordering: beats leave in acceptance order, never duplicated or dropped, except by flush or reset.

## Configuration
- PIPE_REG_SKID_EN defined:
  - one-entry skid S;
  - in_ready = !S_valid, driven directly from a flop with no combinational path from out_ready;
  - in a stalled cycle, the beat accepted while M is full goes to S;
  - when M transfers out, S moves to M on the same edge, and S is then free.
- PIPE_REG_SKID_EN undefined:
  - no S;
  - in_ready = !out_valid || out_ready (combinational from out_ready);
  - area equals the plain register plus the valid bit and stall counter.

## Test plan
- Reset then stream: assert reset, check every output is 0 and in_ready=1. Then stream 4 beats with out_ready=1 (in_opnd=16'hA155, in_instr=19'h7_1234, in_ctrl=13'h1FFF, ...). Each must appear 1 cycle later, bit-exact, with all 13 control bits distinct and unswapped.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - Skid build: 2 beats are accepted, then in_ready=0.
  - Non-skid build: 1 beat is accepted.
  - Both builds: stall_cnt=5; after release, beats exit in order with no loss.
- Flush collision: flush=1 in the same cycle as in_valid=1, out_ready=0, M and S full. Next cycle: out_valid=0, out_ctrl=0, in_ready=1, and the flushed beats never appear.
- Drain bubble: a single beat with in_ctrl=13'h0C01 is consumed and no new input follows. Next cycle: out_valid=0 and out_ctrl=0, while out_instr holds its last value.
- Saturation: force 70000 stalled cycles. stall_cnt must stay at 16'hFFFF.
- Async reset mid-stall: assert reset between clock edges with M and S full. Outputs clear immediately, without waiting for a clock edge.
